// File: rtl/binary_mul_pkg.sv
// Shared definitions for the 7-bit signed pipelined multiplier and its consumers.
package binary_mul_pkg;

  // 7x7 signed multiplier configuration
  localparam int MUL7_P_W     = 13;
  localparam int MUL7_LATENCY = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } sat_res_t;

  // Signed add of two w-bit values carried in 64 bits. ovf flags a result
  // outside the w-bit signed range; sum is clamped to the rails when sat=1,
  // otherwise it is the raw sum (caller keeps the low w bits for a wrap).
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w,
                                       input logic               sat = 1'b1);
    sat_res_t          r;
    logic signed [63:0] s, mx, mn;
    s     = a + b;
    mx    = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn    = -mx - 64'sd1;
    r.ovf = (s > mx) || (s < mn);
    if (sat && (s > mx))      r.sum = mx;
    else if (sat && (s < mn)) r.sum = mn;
    else                      r.sum = s;
    return r;
  endfunction

endpackage

// File: rtl/binary_mul_vld_pipe.sv
// Enable-gated, clearable valid delay line that tracks operands through a
// fixed-latency multiplier so the tail bit marks a real product.
module binary_mul_vld_pipe #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_vld,
  output logic o_vld
);

  logic [DEPTH-1:0] r_vld_pipe;

  // shift in lockstep with the multiplier; clear drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_vld_pipe <= '0;
    else if (i_clr) r_vld_pipe <= '0;
    else if (i_en)  r_vld_pipe <= (r_vld_pipe << 1) | DEPTH'(i_vld);
  end

  assign o_vld = r_vld_pipe[DEPTH-1];

endmodule

// File: rtl/binary_mul_7_1_acc.sv
// Frame accumulator behind the 7-bit signed pipelined multiplier.
// Aligns issued operands with P, sums FRAME_LEN products per frame, presents
// the sum on valid/ready and freezes the multiplier under backpressure.
// Optional: BINARY_MUL_ACC_SAT_EN selects saturating accumulation (default wraps).
module binary_mul_7_1_acc
  import binary_mul_pkg::*;
#(
  parameter  int P_W       = MUL7_P_W,
  parameter  int ACC_W     = 20,
  parameter  int LATENCY   = MUL7_LATENCY,
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             issue_valid,
  input  logic             clr,
  input  logic [P_W-1:0]   P,
  output logic             mul_en,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef BINARY_MUL_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  acc_state_e         r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sticky;
  logic               w_stall, w_vld_aligned, w_take, w_last, w_done;
  logic signed [63:0] w_base, w_p64;
  sat_res_t           w_add;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [63-ACC_W:0]  w_unused_hi;

  assign sum_valid = (r_state == HOLD);
  assign w_stall   = sum_valid & ~sum_ready;
  assign mul_en    = en & ~w_stall;

  binary_mul_vld_pipe #(.DEPTH(LATENCY)) u_vld_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (mul_en),
    .i_clr (clr),
    .i_vld (issue_valid),
    .o_vld (w_vld_aligned)
  );

  // clr wins over accumulation, so a product on a clr edge is dropped
  assign w_take = mul_en & w_vld_aligned & ~clr;
  assign w_last = (frame_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_done = w_take & w_last;

  // first product of a frame starts from zero instead of the stale acc
  assign w_p64  = {{(64-P_W){P[P_W-1]}}, P};
  assign w_base = (frame_cnt == '0) ? 64'sd0 : {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_add  = sat_add(w_base, w_p64, ACC_W, SAT_EN);

  // low bits are either the clamped value or the two's-complement wrap
  assign w_acc_nxt   = w_add.sum[ACC_W-1:0];
  assign w_unused_hi = w_add.sum[63:ACC_W];

  // output state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // HOLD until consumed; a frame finishing on the transfer edge stays in HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_done) w_state_nxt = HOLD;
      HOLD:    if (sum_ready && !w_done) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // accumulator, frame counter and per-frame sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      frame_cnt <= '0;
      r_sticky  <= 1'b0;
    end else if (clr) begin
      r_acc     <= '0;
      frame_cnt <= '0;
      r_sticky  <= 1'b0;
    end else if (w_take) begin
      r_acc <= w_acc_nxt;
      if (w_last) begin
        frame_cnt <= '0;
        r_sticky  <= 1'b0;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        r_sticky  <= r_sticky | w_add.ovf;
      end
    end
  end

  // result register, loaded on the edge of the frame's last product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (w_done) begin
      sum <= w_acc_nxt;
      ovf <= r_sticky | w_add.ovf;
    end
  end

endmodule

// File: tb/tb_binary_mul_7_1_acc.sv
// Bench for binary_mul_7_1_acc: default instance plus a 14-bit-product/16-bit
// accumulator instance for overflow and a FRAME_LEN=1 instance for
// back-to-back transfers. Each has its own behavioural 8-stage multiplier.
module tb_binary_mul_7_1_acc;

  localparam longint MX20 = 524287;
  localparam longint MN20 = -524288;

  logic clk = 1'b0;
  logic rst_n, en, issue_valid, clr, sum_ready;
  logic signed [6:0] A, B;

  logic [12:0] P1;  logic mul_en1, sv1, ovf1;  logic [19:0] sum1;  logic [2:0] fc1;
  logic [13:0] P2;  logic mul_en2, sv2, ovf2;  logic [15:0] sum2;  logic [2:0] fc2;
  logic [12:0] P3;  logic mul_en3, sv3, ovf3;  logic [19:0] sum3;  logic [0:0] fc3;

  int total = 0;
  int bad   = 0;

  typedef struct { longint s; bit o; } exp_t;
  exp_t   q[$];
  longint m_acc = 0;
  int     m_n   = 0;
  bit     m_ovf = 0;

  always #5 clk = ~clk;

  binary_mul_7_1_acc u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .issue_valid(issue_valid), .clr(clr), .P(P1),
    .mul_en(mul_en1), .sum(sum1), .sum_valid(sv1), .sum_ready(sum_ready), .ovf(ovf1),
    .frame_cnt(fc1));

  binary_mul_7_1_acc #(.P_W(14), .ACC_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .issue_valid(issue_valid), .clr(clr), .P(P2),
    .mul_en(mul_en2), .sum(sum2), .sum_valid(sv2), .sum_ready(sum_ready), .ovf(ovf2),
    .frame_cnt(fc2));

  binary_mul_7_1_acc #(.FRAME_LEN(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .issue_valid(issue_valid), .clr(clr), .P(P3),
    .mul_en(mul_en3), .sum(sum3), .sum_valid(sv3), .sum_ready(sum_ready), .ovf(ovf3),
    .frame_cnt(fc3));

  // external multipliers: 8 enabled stages each, full 14-bit product
  logic signed [13:0] mp1 [8];
  logic signed [13:0] mp2 [8];
  logic signed [13:0] mp3 [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 8; i++) mp1[i] <= '0;
    else if (mul_en1) begin
      mp1[0] <= A * B;
      for (int i = 1; i < 8; i++) mp1[i] <= mp1[i-1];
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 8; i++) mp2[i] <= '0;
    else if (mul_en2) begin
      mp2[0] <= A * B;
      for (int i = 1; i < 8; i++) mp2[i] <= mp2[i-1];
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 8; i++) mp3[i] <= '0;
    else if (mul_en3) begin
      mp3[0] <= A * B;
      for (int i = 1; i < 8; i++) mp3[i] <= mp3[i-1];
    end
  end
  assign P1 = mp1[7][12:0];
  assign P2 = mp2[7];
  assign P3 = mp3[7][12:0];

  // product as seen through a 13-bit multiplier output
  function automatic longint p13(input int a, input int b);
    logic signed [12:0] t;
    t = 13'(a * b);
    return longint'(t);
  endfunction

  task automatic model_add(input longint p);
    longint s;
    s = m_acc + p;
    if (s > MX20 || s < MN20) begin
      m_ovf = 1;
`ifdef BINARY_MUL_ACC_SAT_EN
      s = (s > MX20) ? MX20 : MN20;
`else
      s = (s > MX20) ? s - 1048576 : s + 1048576;
`endif
    end
    m_acc = s;
    m_n++;
    if (m_n == 8) begin
      q.push_back('{m_acc, m_ovf});
      m_acc = 0; m_n = 0; m_ovf = 0;
    end
  endtask

  task automatic model_flush();
    q.delete();
    m_acc = 0; m_n = 0; m_ovf = 0;
  endtask

  // hold the operands until an edge where the multiplier is enabled
  task automatic drive(input bit v, input int a, input int b);
    bit taken = 0;
    int n = 0;
    issue_valid = v; A = 7'(a); B = 7'(b);
    while (!taken && n < 200) begin
      @(negedge clk); taken = mul_en1;
      @(posedge clk); #1; n++;
    end
    if (!taken) begin
      total++; bad++;
      $display("FAIL drive_timeout got=stalled want=mul_en");
    end
    if (taken && v) model_add(p13(a, b));
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    model_flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard: every transfer of the default instance pops one expected frame
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && sv1 && sum_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got sum=%0d want=no transfer", $signed(sum1));
      end else begin
        e = q.pop_front();
        if (longint'($signed(sum1)) !== e.s || ovf1 !== e.o) begin
          bad++;
          $display("FAIL sb_sum got sum=%0d ovf=%b want sum=%0d ovf=%b",
                   $signed(sum1), ovf1, e.s, e.o);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; issue_valid = 1'b0; clr = 1'b0; sum_ready = 1'b1;
    A = '0; B = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (sv1 !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b want=0", sv1); end
    total++; if (sum1 !== '0)    begin bad++; $display("FAIL reset_sum got=%0d want=0", sum1); end
    total++; if (ovf1 !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf1); end
    total++; if (fc1 !== '0)     begin bad++; $display("FAIL reset_cnt got=%0d want=0", fc1); end
    total++; if (mul_en1 !== 1'b1) begin bad++; $display("FAIL reset_mul_en got=%b want=1", mul_en1); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    sum_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1, 3, -5);
    repeat (7) @(posedge clk);
    #1;
    total++; if (sv1 !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", sv1); end
    @(posedge clk); #1;
    total++; if (sv1 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", sv1); end
    total++; if ($signed(sum1) !== -120) begin bad++; $display("FAIL basic_sum got=%0d want=-120", $signed(sum1)); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", ovf1); end
    sum_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (sv1 !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b want=0", sv1); end
  endtask

  task automatic test_gaps();
    int n = 0;
    sum_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, i);
      drive(0, 0, 0);
    end
    while (!sv1 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (sv1 !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b want=1", sv1); end
    total++; if ($signed(sum1) !== 204) begin bad++; $display("FAIL gaps_sum got=%0d want=204", $signed(sum1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [2:0] fc_hold;
    sum_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1, 7, -9);
    for (int i = 0; i < 3; i++) drive(1, -2, 11);
    while (!sv1 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (sv1 !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", sv1); end
    fc_hold = fc1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (mul_en1 !== 1'b0 || fc1 !== fc_hold || sv1 !== 1'b1) begin
        bad++;
        $display("FAIL bp_frozen cyc=%0d got mul_en=%b cnt=%0d valid=%b want 0/%0d/1",
                 i, mul_en1, fc1, sv1, fc_hold);
      end
    end
    total++; if ($signed(sum1) !== -504) begin bad++; $display("FAIL bp_held_sum got=%0d want=-504", $signed(sum1)); end
    sum_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1, -2, 11);
    n = 0;
    while (!sv1 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if ($signed(sum1) !== -176 || sv1 !== 1'b1) begin
      bad++; $display("FAIL bp_next_sum got=%0d valid=%b want=-176/1", $signed(sum1), sv1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    sum_ready = 1'b1;
    for (int k = 1; k <= 4; k++) drive(1, 3, k);
    while (!sv3 && n < 50) begin @(posedge clk); #1; n++; end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (sv3 !== 1'b1 || $signed(sum3) !== 3 * k || fc3 !== 1'b0) begin
        bad++;
        $display("FAIL b2b_sum k=%0d got valid=%b sum=%0d cnt=%0d want 1/%0d/0",
                 k, sv3, $signed(sum3), fc3, 3 * k);
      end
      @(posedge clk); #1;
    end
    total++; if (sv3 !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b want=0", sv3); end
  endtask

  task automatic test_overflow();
    int n = 0;
    longint want;
`ifdef BINARY_MUL_ACC_SAT_EN
    want = 32767;
`else
    want = -32768;
`endif
    do_reset();
    sum_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(1, -64, -64);
    while (!sv2 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (sv2 !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", sv2); end
    total++; if (longint'($signed(sum2)) !== want) begin bad++; $display("FAIL ovf_sum got=%0d want=%0d", $signed(sum2), want); end
    total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ovf2); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    int n = 0;
    sum_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 5, 5);
    for (int i = 0; i < 10; i++) drive(0, 0, 0);
    total++; if (fc1 !== 3'd3) begin bad++; $display("FAIL clr_pre_cnt got=%0d want=3", fc1); end
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m_acc = 0; m_n = 0; m_ovf = 0;
    total++; if (fc1 !== 3'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", fc1); end
    for (int i = 0; i < 8; i++) drive(1, 2, 3);
    while (!sv1 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if ($signed(sum1) !== 48 || sv1 !== 1'b1) begin
      bad++; $display("FAIL clr_sum got=%0d valid=%b want=48/1", $signed(sum1), sv1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midframe_reset();
    int n = 0;
    sum_ready = 1'b0;
    for (int i = 0; i < 11; i++) drive(1, 1, 1);
    while (!sv1 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (sv1 !== 1'b1) begin bad++; $display("FAIL rst_pending got=%b want=1", sv1); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    total++;
    if (sv1 !== 1'b0 || sum1 !== '0 || ovf1 !== 1'b0 || fc1 !== '0 || sv2 !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got valid=%b sum=%0d ovf=%b cnt=%0d want 0/0/0/0",
               sv1, sum1, ovf1, fc1);
    end
    model_flush();
    @(posedge clk); #1 rst_n = 1'b1;
    sum_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(1, -3, 4);
    n = 0;
    while (!sv1 && n < 50) begin @(posedge clk); #1; n++; end
    total++; if ($signed(sum1) !== -96) begin bad++; $display("FAIL rst_after_sum got=%0d want=-96", $signed(sum1)); end
    @(posedge clk); #1;
    total++; if (q.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
